entity_motion: RTL

ENTITY_MOTION -- requirements
Module: entity_motion

---
 rtl/game_pkg.sv | 37 +++
 rtl/entity_motion_axis_step.sv | 30 +++
 rtl/entity_motion.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared screen geometry, entity-state layout and motion FSM encoding.
package game_pkg;

  localparam int unsigned LEFT = 144;
  localparam int unsigned TOP  = 35;
  localparam int unsigned TILE = 32;

  // Bounds for a 32x32 entity whose yPos is its bottom edge.
  localparam logic [9:0] X_MIN = 10'(LEFT);
  localparam logic [9:0] X_MAX = 10'(LEFT + 640 - TILE);
  localparam logic [9:0] Y_MIN = 10'(TOP + TILE - 1);
  localparam logic [9:0] Y_MAX = 10'(TOP + 480);

  localparam int unsigned ST_X_LSB  = 22;
  localparam int unsigned ST_Y_LSB  = 12;
  localparam int unsigned ST_XS_LSB = 7;
  localparam int unsigned ST_YS_LSB = 2;
  localparam int unsigned ST_XD_BIT = 1;
  localparam int unsigned ST_YD_BIT = 0;

  typedef struct packed {
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [4:0] x_speed;
    logic [4:0] y_speed;
    logic       x_dir;
    logic       y_dir;
  } entity_state_t;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    IDLE   = 2'd1,
    MOVE_X = 2'd2,
    MOVE_Y = 2'd3
  } motion_state_e;

endpackage

// File: rtl/entity_motion_axis_step.sv
// One-axis step: advance position by speed in the current direction,
// clamp to [LO, HI] and reverse direction on a wall hit.
module axis_step #(
  parameter logic [9:0] LO = 10'd144,
  parameter logic [9:0] HI = 10'd752
) (
  input  logic [9:0] i_pos,
  input  logic [4:0] i_speed,
  input  logic       i_dir,
  output logic [9:0] o_pos,
  output logic       o_dir
);

  logic signed [10:0] w_next;

  always_comb begin
    if (i_dir) w_next = $signed({1'b0, i_pos}) + $signed({6'd0, i_speed});
    else       w_next = $signed({1'b0, i_pos}) - $signed({6'd0, i_speed});
    o_pos = w_next[9:0];
    o_dir = i_dir;
    if (w_next > $signed({1'b0, HI})) begin
      o_pos = HI;
      o_dir = 1'b0;
    end else if (w_next < $signed({1'b0, LO})) begin
      o_pos = LO;
      o_dir = 1'b1;
    end
  end

endmodule

// File: rtl/entity_motion.sv
// Per-frame entity motion: x step/bounce, then y gravity/jump/floor,
// published together on state_out with a one-cycle update_done pulse.
module entity_motion
  import game_pkg::*;
#(
  parameter bit         GRAVITY_EN = 1'b1,
  parameter logic [4:0] JUMP_SPEED = 5'd12,
  parameter logic [4:0] MAX_FALL   = 5'd8
) (
  input  logic        sim_clk,
  input  logic        reset,
  input  logic [31:0] init_state,
  input  logic        frame_tick,
  input  logic        jump,
  output logic [31:0] state_out,
  output logic        on_ground,
  output logic        update_done
);

  motion_state_e r_state, w_next_state;
  entity_state_t r_cur;
  logic [31:0]   r_out;
  logic          r_on_ground;
  logic          r_jump;
  logic          r_done;

  logic [9:0]    w_x_pos;
  logic          w_x_dir;
  logic [9:0]    w_y_pos;
  logic [4:0]    w_y_speed;
  logic          w_y_dir;
  logic          w_on_ground;
  logic [4:0]    w_ys_eff;
  logic          w_yd_eff;
  logic [10:0]   w_sum;

  axis_step #(.LO(X_MIN), .HI(X_MAX)) u_x_step (
    .i_pos   (r_cur.x_pos),
    .i_speed (r_cur.x_speed),
    .i_dir   (r_cur.x_dir),
    .o_pos   (w_x_pos),
    .o_dir   (w_x_dir)
  );

  always_ff @(posedge sim_clk or posedge reset) begin
    if (reset) r_state <= LOAD;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      LOAD:    w_next_state = IDLE;
      IDLE:    if (frame_tick) w_next_state = MOVE_X;
      MOVE_X:  w_next_state = MOVE_Y;
      MOVE_Y:  w_next_state = IDLE;
      default: w_next_state = LOAD;
    endcase
  end

  // Rising test uses y < Y_MIN + speed so the unsigned difference never wraps.
  always_comb begin
    w_ys_eff    = r_cur.y_speed;
    w_yd_eff    = r_cur.y_dir;
    w_sum       = '0;
    w_y_pos     = r_cur.y_pos;
    w_y_speed   = r_cur.y_speed;
    w_y_dir     = r_cur.y_dir;
    w_on_ground = 1'b0;
    if (GRAVITY_EN) begin
      w_on_ground = r_on_ground;
      if (r_jump && r_on_ground) begin
        w_ys_eff    = JUMP_SPEED;
        w_yd_eff    = 1'b1;
        w_on_ground = 1'b0;
      end
      w_y_dir = w_yd_eff;
      if (w_yd_eff) begin
        w_sum = {1'b0, r_cur.y_pos} - {6'd0, w_ys_eff};
        if ({1'b0, r_cur.y_pos} < ({1'b0, Y_MIN} + {6'd0, w_ys_eff})) begin
          w_y_pos   = Y_MIN;
          w_y_speed = '0;
          w_y_dir   = 1'b0;
        end else begin
          w_y_pos   = w_sum[9:0];
          w_y_speed = (w_ys_eff == 5'd0) ? 5'd0 : w_ys_eff - 5'd1;
          w_y_dir   = (w_ys_eff > 5'd1);
        end
      end else begin
        w_sum = {1'b0, r_cur.y_pos} + {6'd0, w_ys_eff};
        if (w_sum >= {1'b0, Y_MAX}) begin
          w_y_pos     = Y_MAX;
          w_y_speed   = '0;
          w_on_ground = 1'b1;
        end else begin
          w_y_pos     = w_sum[9:0];
          w_y_speed   = (w_ys_eff >= MAX_FALL) ? MAX_FALL : w_ys_eff + 5'd1;
          w_on_ground = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge sim_clk or posedge reset) begin
    if (reset) begin
      r_cur       <= '0;
      r_out       <= '0;
      r_on_ground <= 1'b0;
      r_jump      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        LOAD: begin
          r_cur       <= entity_state_t'(init_state);
          r_on_ground <= 1'b0;
          r_jump      <= 1'b0;
        end
        IDLE: begin
          if (frame_tick) r_jump <= jump & GRAVITY_EN;
        end
        MOVE_X: begin
          r_cur.x_pos <= w_x_pos;
          r_cur.x_dir <= w_x_dir;
        end
        MOVE_Y: begin
          r_cur.y_pos   <= w_y_pos;
          r_cur.y_speed <= w_y_speed;
          r_cur.y_dir   <= w_y_dir;
          r_on_ground   <= w_on_ground;
          r_jump        <= 1'b0;
          r_out         <= {r_cur.x_pos, w_y_pos, r_cur.x_speed, w_y_speed,
                            r_cur.x_dir, w_y_dir};
          r_done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state_out   = r_out;
  assign on_ground   = r_on_ground;
  assign update_done = r_done;

endmodule
